// File: rtl/loadable_pkg.sv
// Shared definitions for the loadable shift register and the
// multiplier controller: shift directions, FSM states, cell selects.
package loadable_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Next-value select for one storage cell
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_SHR  = 2'd2,
        SEL_SHL  = 2'd3
    } cell_sel_t;

endpackage

// File: rtl/loadable_shift_cell.sv
// One bit of shift-register storage with synchronous clear.
// Ports: clk, clr (sync, to RST_BIT), sel (hold/load/shr/shl),
//   load_bit (parallel data), shr_bit (value taken on a right shift,
//   i.e. the higher neighbour), shl_bit (value taken on a left shift,
//   i.e. the lower neighbour), q (stored bit).
module loadable_shift_cell
    import loadable_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      clr,
    input  cell_sel_t sel,
    input  logic      load_bit,
    input  logic      shr_bit,
    input  logic      shl_bit,
    output logic      q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RST_BIT;
        end else begin
            unique case (sel)
                SEL_HOLD: q <= q;
                SEL_LOAD: q <= load_bit;
                SEL_SHR:  q <= shr_bit;
                SEL_SHL:  q <= shl_bit;
            endcase
        end
    end

endmodule

// File: rtl/loadable_shift_reg.sv
// WIDTH-bit loadable left/right shift register with shift counter.
// Ports: clk, clr (sync active-high), load/d (parallel load),
//   shift_en/dir/sin (serial shift), q, sout, cnt, done.
module loadable_shift_reg
    import loadable_pkg::*;
#(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int                CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   cnt_inc;
    logic            sout_nxt;
    cell_sel_t       sel;

    assign cnt_inc = cnt + CW'(1);
    assign done    = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sout_nxt  = sout;
        sel       = SEL_HOLD;
        if (load) begin
            state_nxt = ST_ACTIVE;
            cnt_nxt   = '0;
            sout_nxt  = 1'b0;
            sel       = SEL_LOAD;
        end else if (shift_en && state == ST_ACTIVE) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
                state_nxt = ST_DONE;
            end
            if (dir == DIR_LEFT) begin
                sel      = SEL_SHL;
                sout_nxt = q[WIDTH-1];
            end else begin
                sel      = SEL_SHR;
                sout_nxt = q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sout  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sout  <= sout_nxt;
        end
    end

    // End cells take sin in place of the missing neighbour
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shr_bit;
        logic shl_bit;

        if (i == WIDTH - 1) begin : g_top
            assign shr_bit = sin;
        end else begin : g_mid_r
            assign shr_bit = q[i+1];
        end

        if (i == 0) begin : g_bot
            assign shl_bit = sin;
        end else begin : g_mid_l
            assign shl_bit = q[i-1];
        end

        loadable_shift_cell #(
            .RST_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk      (clk),
            .clr      (clr),
            .sel      (sel),
            .load_bit (d[i]),
            .shr_bit  (shr_bit),
            .shl_bit  (shl_bit),
            .q        (q[i])
        );
    end

endmodule

// File: tb/tb_loadable_shift_reg.sv
// Scoreboard bench for loadable_shift_reg (WIDTH=4, RESET_VALUE=0):
// directed scenarios followed by randomized traffic.
module tb_loadable_shift_reg;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  d = '0;
    logic          shift_en = 1'b0;
    logic          dir = 1'b0;
    logic          sin = 1'b0;
    logic [W-1:0]  q;
    logic          sout;
    logic [CW-1:0] cnt;
    logic          done;

    loadable_shift_reg #(
        .WIDTH       (W),
        .RESET_VALUE (4'b0000)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .d        (d),
        .shift_en (shift_en),
        .dir      (dir),
        .sin      (sin),
        .q        (q),
        .sout     (sout),
        .cnt      (cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int sout;
        int cnt;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   finished = 0;

    // Reference model: 0 idle, 1 accepting shifts, 2 finished
    int m_q    = 0;
    int m_sout = 0;
    int m_cnt  = 0;
    int m_mode = 0;

    function automatic void model_edge(
        input int c, input int l, input int dd,
        input int se, input int dr, input int si
    );
        if (c != 0) begin
            m_q = 0; m_sout = 0; m_cnt = 0; m_mode = 0;
        end else if (l != 0) begin
            m_q = dd; m_sout = 0; m_cnt = 0; m_mode = 1;
        end else if (se != 0 && m_mode == 1) begin
            if (dr != 0) begin
                m_sout = (m_q >> (W - 1)) & 1;
                m_q = ((m_q * 2) + si) % (1 << W);
            end else begin
                m_sout = m_q % 2;
                m_q = (m_q / 2) + si * (1 << (W - 1));
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == W) m_mode = 2;
        end
    endfunction

    task automatic step(
        input bit c, input bit l, input logic [W-1:0] dd,
        input bit se, input bit dr, input bit si
    );
        exp_t e;
        @(negedge clk);
        clr = c; load = l; d = dd;
        shift_en = se; dir = dr; sin = si;
        @(posedge clk);
        model_edge(c, l, dd, se, dr, si);
        e.q = m_q; e.sout = m_sout; e.cnt = m_cnt;
        e.done = (m_mode == 2) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Direct constant check, sampled just after the edge
    task automatic anchor(
        input string name, input logic [W-1:0] eq,
        input logic es, input logic [CW-1:0] ec, input logic ed
    );
        #2;
        checks++;
        if (q !== eq || sout !== es || cnt !== ec || done !== ed) begin
            failures++;
            $display("FAIL %s: got q=%b sout=%b cnt=%0d done=%b want q=%b sout=%b cnt=%0d done=%b",
                     name, q, sout, cnt, done, eq, es, ec, ed);
        end
    endtask

    // Monitor: outputs are valid every cycle, one expectation per edge
    initial begin : monitor
        int cyc;
        exp_t e;
        cyc = 0;
        while (!(finished && exp_q.size() == 0) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (q !== W'(e.q) || sout !== e.sout[0] ||
                    cnt !== CW'(e.cnt) || done !== e.done[0]) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got q=%b sout=%b cnt=%0d done=%b want q=%b sout=%0d cnt=%0d done=%0d",
                             $time, q, sout, cnt, done, W'(e.q), e.sout, e.cnt, e.done);
                end
            end
        end
        if (cyc >= 5000) begin
            failures++;
            $display("FAIL timeout: monitor cycle budget expired, pending=%0d want 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : driver
        bit c, l, se, dr, si;
        logic [W-1:0] dd;

        // 1: reset then shifts without load are ignored
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        anchor("reset", 4'b0000, 1'b0, 3'd0, 1'b0);
        repeat (3) step(0, 0, '0, 1, 0, 1);
        anchor("idle_ignore", 4'b0000, 1'b0, 3'd0, 1'b0);

        // 2: right shifts to completion, extra shift ignored
        step(0, 1, 4'b1011, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        anchor("shr1", 4'b0101, 1'b1, 3'd1, 1'b0);
        repeat (3) step(0, 0, '0, 1, 0, 0);
        anchor("shr4_done", 4'b0000, 1'b1, 3'd4, 1'b1);
        step(0, 0, '0, 1, 0, 0);
        anchor("shr5_ignored", 4'b0000, 1'b1, 3'd4, 1'b1);

        // 6: restart from done
        step(0, 1, 4'b0110, 0, 0, 0);
        anchor("restart", 4'b0110, 1'b0, 3'd0, 1'b0);
        step(0, 0, '0, 1, 0, 1);
        anchor("restart_shr", 4'b1011, 1'b0, 3'd1, 1'b0);

        // 3: left then right
        step(0, 1, 4'b1011, 0, 0, 0);
        step(0, 0, '0, 1, 1, 1);
        anchor("shl", 4'b0111, 1'b1, 3'd1, 1'b0);
        step(0, 0, '0, 1, 0, 0);
        anchor("shl_shr", 4'b0011, 1'b1, 3'd2, 1'b0);

        // 4: load beats shift at cnt=2
        step(0, 1, 4'b1100, 1, 0, 1);
        anchor("load_beats_shift", 4'b1100, 1'b0, 3'd0, 1'b0);

        // 5: clear mid-operation at cnt=3
        repeat (3) step(0, 0, '0, 1, 1, 0);
        step(1, 1, 4'b1111, 1, 0, 1);
        anchor("clr_mid", 4'b0000, 1'b0, 3'd0, 1'b0);
        step(0, 0, '0, 1, 1, 1);
        anchor("clr_then_shift", 4'b0000, 1'b0, 3'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            c  = ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 6) == 0);
            se = ($urandom_range(0, 3) != 0);
            dr = $urandom_range(0, 1);
            si = $urandom_range(0, 1);
            dd = W'($urandom);
            step(c, l, dd, se, dr, si);
        end

        @(negedge clk);
        clr = 0; load = 0; shift_en = 0;
        finished = 1;
    end

endmodule
